// File: rtl/mv_select.sv
// mv_select: per-lane running minimum SAD and its motion vector over a raster-scanned search window.
module mv_select #(
  parameter int NUM_PU = 16,
  parameter int SAD_W  = 14,
  parameter int SR     = 32,
  parameter int MV_W   = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     sad_valid,
  input  logic [NUM_PU*SAD_W-1:0]  sad_in,
  output logic [NUM_PU*SAD_W-1:0]  best_sad,
  output logic [NUM_PU*MV_W-1:0]   best_mvx,
  output logic [NUM_PU*MV_W-1:0]   best_mvy,
  output logic                     busy,
  output logic                     done
);
  localparam logic [MV_W-1:0] POS_MIN = MV_W'(-SR);
  localparam logic [MV_W-1:0] POS_MAX = MV_W'(SR - 1);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nxt;
  logic [MV_W-1:0] pos_x, pos_y;
  logic beat, x_end, last, init;
  assign beat  = (state == SCAN) && sad_valid;
  assign x_end = pos_x == POS_MAX;
  assign last  = x_end && (pos_y == POS_MAX);
  assign init  = (state == IDLE) && start;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  always_comb begin
    state_nxt = (state == IDLE) ? (start ? SCAN : IDLE) :
                (state == SCAN) ? ((beat && last) ? DONE : SCAN) : IDLE;
  end
  always_comb begin
    busy = state == SCAN;
    done = state == DONE;
  end
  // Raster position of the candidate that the next valid beat belongs to.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pos_x <= POS_MIN;
      pos_y <= POS_MIN;
    end else if (init) begin
      pos_x <= POS_MIN;
      pos_y <= POS_MIN;
    end else if (beat) begin
      pos_x <= x_end ? POS_MIN : pos_x + 1'b1;
      if (x_end) pos_y <= last ? POS_MIN : pos_y + 1'b1;
    end
  for (genvar i = 0; i < NUM_PU; i++) begin : g_lane
    logic [SAD_W-1:0] sad_q, s;
    logic [MV_W-1:0]  mvx_q, mvy_q;
    logic             hit;
    assign s   = sad_in[i*SAD_W +: SAD_W];
    // Strict compare so ties keep the earlier raster position.
    assign hit = beat && (s < sad_q);
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        sad_q <= '1;
        mvx_q <= '0;
        mvy_q <= '0;
      end else if (init) begin
        sad_q <= '1;
        mvx_q <= '0;
        mvy_q <= '0;
      end else if (hit) begin
        sad_q <= s;
        mvx_q <= pos_x;
        mvy_q <= pos_y;
      end
    assign best_sad[i*SAD_W +: SAD_W] = sad_q;
    assign best_mvx[i*MV_W +: MV_W]   = mvx_q;
    assign best_mvy[i*MV_W +: MV_W]   = mvy_q;
  end
endmodule

// File: doc/mv_select.md
Name: mv_select

Overview:
- Downstream of the SAD min-comparison stage in the motion-estimation datapath.
- Consumes one packed vector of per-partition SADs per search candidate.
- Walks the search window in raster order and tracks, for every partition lane, the minimum SAD and the motion vector (MV) where that minimum occurred.
- At the end of a window it reports the best SAD and MV per lane to the mode-decision logic.

Parameters:
- NUM_PU, 16: number of partition lanes tracked in parallel.
- SAD_W, 14: width of one lane's SAD, unsigned.
- SR, 32: search range; candidate MV components run from -SR to SR-1, giving (2*SR)^2 candidates.
- MV_W, 6: width of one signed MV component. Constraint: 2^(MV_W-1) >= SR.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: single-cycle request to begin a new window scan.
- sad_valid, input, 1: sad_in carries the SADs for the current candidate.
- sad_in, input, NUM_PU*SAD_W: packed lane SADs; lane i is at bits [i*SAD_W +: SAD_W].
- best_sad, output, NUM_PU*SAD_W: running or final minimum SAD per lane, same packing as sad_in.
- best_mvx, output, NUM_PU*MV_W: signed x MV of each lane's minimum.
- best_mvy, output, NUM_PU*MV_W: signed y MV of each lane's minimum.
- busy, output, 1: high while in SCAN.
- done, output, 1: one-cycle pulse when the window is complete.

Behaviour:
- Reset: asynchronous on rst_n low, effective immediately, including mid-scan. Values after reset:
  - FSM = IDLE.
  - best_sad = all ones in every lane.
  - best_mvx = 0, best_mvy = 0.
  - Position counters: pos_x = -SR, pos_y = -SR.
  - busy = 0, done = 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - sad_valid is ignored.
  - On start=1: reinitialise best_sad to all ones, both MVs to 0, pos_x = pos_y = -SR. Next state is SCAN.
- SCAN:
  - Each cycle with sad_valid=1 is one beat, belonging to the candidate (pos_x, pos_y).
  - Per lane, in parallel: if sad_in lane < best_sad lane (strict, unsigned), then best_sad, best_mvx and best_mvy for that lane load the lane SAD, pos_x and pos_y.
  - Ties keep the earlier raster position.
  - Register update is visible the cycle after the beat (latency 1).
  - Position advance per beat: pos_x increments. At pos_x = SR-1 it wraps to -SR and pos_y increments.
  - The beat at (SR-1, SR-1) is the last one; the next state is DONE.
  - Cycles with sad_valid=0 change nothing. Gaps of any length are legal.
  - start during SCAN is ignored.
- DONE:
  - done=1 for exactly this cycle; best_* already hold the final values.
  - sad_valid and start are ignored.
  - Next state is IDLE unconditionally.
- Output stability:
  - best_* stay stable from done until the cycle after the next accepted start.
  - busy = (state == SCAN).
- No arithmetic beyond compare and counter increments. Counters are MV_W-bit signed; wrap is explicit, never overflow.
- A start and the last beat can never coincide, because start is only sampled in IDLE.

Test Plan:
All scenarios except 6 use SR=2 (16 beats; raster beat k maps to x = -2 + k%4, y = -2 + k/4) and NUM_PU=16, SAD_W=14.
1. Reset and idle: hold rst_n=0, then release; drive sad_valid=1 while IDLE -> best_sad = all ones (16383 per lane), MVs 0, busy=0, done=0, no state change.
2. Single minimum: start, 16 beats; all lanes 100 except lane 3 = 7 at beat 5 -> lane 3 gives best_sad=7 at (-1,-1); other lanes give 100 at (-2,-2); done pulses one cycle after beat 15; busy falls in the same cycle.
3. Tie and independence:
   - Lane 0 = 10 at beats 3 and 9, 50 elsewhere -> lane 0 MV (1,-2).
   - Lane 1 decreasing 200-k -> lane 1 best_sad 185 at (1,1).
4. Gapped input: same stimulus as scenario 2 with random sad_valid=0 cycles inserted -> identical results; done only after the 16th valid beat. start pulsed mid-scan has no effect.
5. Reset mid-scan: assert rst_n=0 after 8 beats -> outputs return to reset values, FSM is IDLE; further sad_valid beats are ignored until a new start, after which a full 16-beat scan completes normally.
6. Default SR=32: 4096 beats, minimum 1 injected on lane 15 at beat 4095 -> lane 15 gives best_sad=1 at (31,31); done arrives after exactly 4096 valid beats.
